// File: rtl/sdrd_cap_pkg.sv
// Shared types and helpers for the SDRD lock-read frame capture block.
package sdrd_cap_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    HOLD
  } cap_state_t;

  // A lock read access: serial select asserted, address 01 on BA13/BA12, read cycle.
  function automatic logic lock_sel(input logic sser, input logic ba13,
                                    input logic ba12, input logic br_w);
    return ~sser & ~ba13 & ba12 & br_w;
  endfunction

endpackage

// File: rtl/sdrd_sync.sv
// N-bit, STAGES-deep flop synchronizer with a per-bit reset value.
module sdrd_sync #(
  parameter int             STAGES  = 2,
  parameter int             N       = 1,
  parameter logic [N-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [STAGES-1:0][N-1:0] stage_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= {STAGES{RST_VAL}};
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/sdrd_frame_capture.sv
// Samples one SDRD bit per lock read access, packs MSB-first frames and
// offers them to the host over valid/ready with sticky drop/error flags.
module sdrd_frame_capture
  import sdrd_cap_pkg::*;
#(
  parameter int FRAME_BITS   = 8,
  parameter int SAMPLE_DLY   = 2,
  parameter int IDLE_TIMEOUT = 1024,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sser,
  input  logic                  ba13,
  input  logic                  ba12,
  input  logic                  br_w,
  input  logic                  sdrd,
  input  logic                  lock_q3_n,
  output logic [FRAME_BITS-1:0] frm_data,
  output logic                  frm_valid,
  input  logic                  frm_ready,
  output logic [CNT_W-1:0]      bit_cnt,
  output logic                  overrun,
  output logic                  bit_err,
  input  logic                  clr_flags
);

  localparam int TMR_W = $clog2(IDLE_TIMEOUT + 1);

  logic sser_s, ba13_s, ba12_s, br_w_s, sdrd_s, lock_q3_n_s;

  // sser resets high so the bus looks deselected until real data arrives.
  sdrd_sync #(
    .STAGES (SYNC_STAGES),
    .N      (6),
    .RST_VAL(6'b100000)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  ({sser,   ba13,   ba12,   br_w,   sdrd,   lock_q3_n}),
    .q_o  ({sser_s, ba13_s, ba12_s, br_w_s, sdrd_s, lock_q3_n_s})
  );

  logic       sel, sel_prev_q, sel_rise, sample_ev;
  cap_state_t state_q;
  logic [3:0] dly_q;

  assign sel       = lock_sel(sser_s, ba13_s, ba12_s, br_w_s);
  assign sel_rise  = sel & ~sel_prev_q;
  assign sample_ev = (state_q == DELAY) && sel && (dly_q == 4'd0);

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dly_q      <= '0;
      sel_prev_q <= 1'b0;
    end else begin
      sel_prev_q <= sel;
      case (state_q)
        IDLE: begin
          if (sel_rise) begin
            state_q <= DELAY;
            dly_q   <= 4'(SAMPLE_DLY - 1);
          end
        end
        DELAY: begin
          if (!sel)                state_q <= IDLE;
          else if (dly_q == 4'd0)  state_q <= HOLD;
          else                     dly_q   <= dly_q - 4'd1;
        end
        HOLD: begin
          if (!sel) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [FRAME_BITS-1:0] shift_q, shift_d, shifted, frm_data_q, frm_data_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic                  frm_valid_q, frm_valid_d, overrun_q, overrun_d, bit_err_q, bit_err_d;
  logic                  good_sample, bad_sample, frame_done, timeout, drop;

  assign shifted     = {shift_q[FRAME_BITS-2:0], sdrd_s};
  assign good_sample = sample_ev & lock_q3_n_s;
  assign bad_sample  = sample_ev & ~lock_q3_n_s;
  assign frame_done  = good_sample && (bit_cnt_q == CNT_W'(FRAME_BITS - 1));
  assign timeout     = (bit_cnt_q != '0) && (tmr_q == TMR_W'(IDLE_TIMEOUT));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tmr_d     = tmr_q;
    if (bad_sample) begin
      shift_d   = '0;
      bit_cnt_d = '0;
      tmr_d     = '0;
    end else if (good_sample) begin
      shift_d   = shifted;
      bit_cnt_d = frame_done ? '0 : bit_cnt_q + CNT_W'(1);
      tmr_d     = '0;
    end else if (timeout) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if ((bit_cnt_q != '0) && (tmr_q != TMR_W'(IDLE_TIMEOUT))) begin
      tmr_d = tmr_q + TMR_W'(1);
    end
  end

  // A new frame may replace the held one only if the host takes the old one this cycle.
  always_comb begin
    frm_data_d  = frm_data_q;
    frm_valid_d = frm_valid_q;
    drop        = 1'b0;
    if (frame_done) begin
      if (!frm_valid_q || frm_ready) begin
        frm_data_d  = shifted;
        frm_valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (frm_valid_q && frm_ready) begin
      frm_valid_d = 1'b0;
    end
    overrun_d = drop       | (overrun_q & ~clr_flags);
    bit_err_d = bad_sample | (bit_err_q & ~clr_flags);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      tmr_q       <= '0;
      frm_data_q  <= '0;
      frm_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      bit_err_q   <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      tmr_q       <= tmr_d;
      frm_data_q  <= frm_data_d;
      frm_valid_q <= frm_valid_d;
      overrun_q   <= overrun_d;
      bit_err_q   <= bit_err_d;
    end
  end

  assign frm_data  = frm_data_q;
  assign frm_valid = frm_valid_q;
  assign bit_cnt   = bit_cnt_q;
  assign overrun   = overrun_q;
  assign bit_err   = bit_err_q;

endmodule

// File: tb/tb_sdrd_frame_capture.sv
// Self-checking bench for sdrd_frame_capture: vector table, corner sequences, random accesses.
module tb_sdrd_frame_capture;

  localparam int FB = 8;
  localparam int SD = 2;
  localparam int TO = 1024;
  localparam int SS = 2;
  localparam logic [2:0] ACC = 3'b011;  // {ba13, ba12, br_w} of a lock read

  logic          clk, rst_n;
  logic          sser, ba13, ba12, br_w, sdrd, lock_q3_n, frm_ready, clr_flags;
  logic [FB-1:0] frm_data;
  logic          frm_valid, overrun, bit_err;
  logic [5:0]    bit_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] acc_q[$];
  logic [7:0] exp_q[$];

  sdrd_frame_capture #(
    .FRAME_BITS  (FB),
    .SAMPLE_DLY  (SD),
    .IDLE_TIMEOUT(TO),
    .SYNC_STAGES (SS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sser     (sser),
    .ba13     (ba13),
    .ba12     (ba12),
    .br_w     (br_w),
    .sdrd     (sdrd),
    .lock_q3_n(lock_q3_n),
    .frm_data (frm_data),
    .frm_valid(frm_valid),
    .frm_ready(frm_ready),
    .bit_cnt  (bit_cnt),
    .overrun  (overrun),
    .bit_err  (bit_err),
    .clr_flags(clr_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Host side: record every frame actually handed over.
  always @(negedge clk) begin
    if (rst_n && frm_valid && frm_ready) acc_q.push_back(frm_data);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit hit before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic access(input logic b, input logic lk, input int len,
                        input logic [2:0] addr, input int gap);
    sser = 1'b0;
    {ba13, ba12, br_w} = addr;
    sdrd = b;
    lock_q3_n = lk;
    tick(len);
    sser = 1'b1;
    tick(gap);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) access(v[i], 1'b1, 6, ACC, 4);
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
  endtask

  typedef struct {
    logic       sdrd;
    logic       lock;
    int         len;
    logic [5:0] exp_cnt;
    logic       exp_err;
  } vec_t;

  vec_t vecs[15];

  // Behavioural model state for the random phase.
  int         m_cnt;
  logic [7:0] m_shift, m_data;
  logic       m_valid, m_ovr, m_err;

  initial begin
    logic [7:0] b2;
    b2 = 8'hB2;
    for (int i = 0; i < 8; i++)
      vecs[i] = '{b2[7-i], 1'b1, 6, (i == 7) ? 6'd0 : 6'(i + 1), 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 6, 6'd1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 2, 6'd1, 1'b0};  // too short to be sampled
    vecs[10] = '{1'b0, 1'b1, 6, 6'd2, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 6, 6'd3, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 6, 6'd4, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 6, 6'd5, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 6, 6'd0, 1'b1};  // driven-off sample: resync

    rst_n = 1'b0; sser = 1'b1; ba13 = 1'b0; ba12 = 1'b0; br_w = 1'b0;
    sdrd = 1'b1; lock_q3_n = 1'b1; frm_ready = 1'b0; clr_flags = 1'b0;
    #12;
    check("rst_data", frm_data, 0);
    check("rst_valid", frm_valid, 0);
    check("rst_cnt", bit_cnt, 0);
    check("rst_ovr", overrun, 0);
    check("rst_err", bit_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Vector table: 0xB2 frame with host always ready, short access, lock error.
    frm_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      access(vecs[i].sdrd, vecs[i].lock, vecs[i].len, ACC, 4);
      check($sformatf("vec%0d_cnt", i), bit_cnt, vecs[i].exp_cnt);
      check($sformatf("vec%0d_err", i), bit_err, vecs[i].exp_err);
      check($sformatf("vec%0d_valid", i), frm_valid, 0);
    end
    check("b2_frames", acc_q.size(), 1);
    if (acc_q.size() > 0) check("b2_data", acc_q[0], 8'hB2);
    pulse_clr();
    check("err_clr", bit_err, 0);
    acc_q.delete();

    // Overrun: second frame arrives while the first is still held.
    frm_ready = 1'b0;
    send_byte(8'hA5);
    check("ovr_v1", frm_valid, 1);
    check("ovr_d1", frm_data, 8'hA5);
    check("ovr_o1", overrun, 0);
    send_byte(8'h3C);
    check("ovr_v2", frm_valid, 1);
    check("ovr_d2", frm_data, 8'hA5);
    check("ovr_o2", overrun, 1);
    check("ovr_cnt", bit_cnt, 0);
    pulse_clr();
    check("ovr_clr", overrun, 0);
    check("ovr_hold", frm_valid, 1);
    frm_ready = 1'b1;
    tick(1);
    frm_ready = 1'b0;
    check("ovr_drain_v", frm_valid, 0);
    check("ovr_drain_n", acc_q.size(), 1);
    if (acc_q.size() > 0) check("ovr_drain_d", acc_q[0], 8'hA5);
    acc_q.delete();

    // Idle timeout discards a partial frame, then capture resumes cleanly.
    access(1'b1, 1'b1, 6, ACC, 4);
    access(1'b0, 1'b1, 6, ACC, 4);
    access(1'b1, 1'b1, 6, ACC, 4);
    check("to_cnt3", bit_cnt, 3);
    tick(TO - 50);
    check("to_before", bit_cnt, 3);
    tick(100);
    check("to_after", bit_cnt, 0);
    send_byte(8'h0F);
    check("to_valid", frm_valid, 1);
    check("to_data", frm_data, 8'h0F);
    frm_ready = 1'b1;
    tick(1);
    frm_ready = 1'b0;
    acc_q.delete();

    // Async reset while a frame is held, bit_err is set and 4 bits are pending.
    send_byte(8'h5A);
    access(1'b1, 1'b0, 6, ACC, 4);
    for (int i = 0; i < 4; i++) access(1'b1, 1'b1, 6, ACC, 4);
    check("mr_cnt", bit_cnt, 4);
    check("mr_valid", frm_valid, 1);
    check("mr_err", bit_err, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_rst_data", frm_data, 0);
    check("mr_rst_valid", frm_valid, 0);
    check("mr_rst_cnt", bit_cnt, 0);
    check("mr_rst_ovr", overrun, 0);
    check("mr_rst_err", bit_err, 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    send_byte(8'hC3);
    check("mr_new_valid", frm_valid, 1);
    check("mr_new_data", frm_data, 8'hC3);
    check("mr_new_cnt", bit_cnt, 0);

    // Random accesses against a transaction-level model.
    m_cnt = 0; m_shift = '0; m_data = 8'hC3; m_valid = 1'b1; m_ovr = 1'b0; m_err = 1'b0;
    acc_q.delete();
    exp_q.delete();
    for (int k = 0; k < 40; k++) begin
      int typ, len, gap;
      logic b, lk, r, sampled;
      logic [2:0] addr;
      typ = $urandom_range(0, 9);
      b   = 1'($urandom);
      lk  = ($urandom_range(0, 9) != 0);
      r   = 1'($urandom);
      gap = $urandom_range(4, 7);
      addr = ACC;
      if (typ <= 5) begin
        len = $urandom_range(6, 9);
        sampled = 1'b1;
      end else if (typ <= 7) begin
        len = $urandom_range(1, 2);
        sampled = 1'b0;
      end else begin
        len = $urandom_range(6, 9);
        sampled = 1'b0;
        do addr = 3'($urandom_range(0, 7)); while (addr == ACC);
      end
      frm_ready = r;
      if (r && m_valid) begin
        exp_q.push_back(m_data);
        m_valid = 1'b0;
      end
      access(b, lk, len, addr, gap);
      if (sampled) begin
        if (lk) begin
          m_shift = {m_shift[6:0], b};
          m_cnt++;
          if (m_cnt == FB) begin
            m_cnt = 0;
            if (!m_valid) begin
              m_valid = 1'b1;
              m_data  = m_shift;
            end else begin
              m_ovr = 1'b1;
            end
          end
        end else begin
          m_err = 1'b1;
          m_cnt = 0;
          m_shift = '0;
        end
      end
      if (r && m_valid) begin
        exp_q.push_back(m_data);
        m_valid = 1'b0;
      end
      check($sformatf("rnd%0d_cnt", k), bit_cnt, m_cnt);
      check($sformatf("rnd%0d_valid", k), frm_valid, m_valid);
      check($sformatf("rnd%0d_ovr", k), overrun, m_ovr);
      check($sformatf("rnd%0d_err", k), bit_err, m_err);
    end
    frm_ready = 1'b1;
    if (m_valid) exp_q.push_back(m_data);
    tick(2);
    frm_ready = 1'b0;
    check("rnd_frames_n", acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < acc_q.size()) check($sformatf("rnd_frame%0d", i), acc_q[i], exp_q[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
